// File: rtl/mul_share_pkg.sv
// Shared types and helpers for the mul_share_arb block.
//   state_e   : scheduler FSM states
//   idx_width : bit width needed to index NumReq requesters (at least 1)
package mul_share_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StResp
   } state_e;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mul_share_rr_pick.sv
// Rotate-priority encoder: picks the first asserted request at or above ptr_i,
// wrapping modulo NumReq.
//   req_v_i     : request vector
//   ptr_i       : index with highest priority this cycle
//   grant_oh_o  : one-hot grant, zero if no request
//   grant_idx_o : index of the grant, zero if no request
module mul_share_rr_pick
   import mul_share_pkg::*;
#(
   parameter int unsigned NumReq = 2,
   parameter int unsigned IdxW   = idx_width(NumReq)
) (
   input  logic [NumReq-1:0] req_v_i,
   input  logic [IdxW-1:0]   ptr_i,
   output logic [NumReq-1:0] grant_oh_o,
   output logic [IdxW-1:0]   grant_idx_o
);

   logic [31:0] cand;
   logic        found;

   always_comb begin
      grant_oh_o  = '0;
      grant_idx_o = '0;
      found       = 1'b0;
      cand        = '0;
      for (int unsigned k = 0; k < NumReq; k++) begin
         // ptr_i < NumReq, so one conditional subtract performs the wrap.
         cand = 32'(ptr_i) + k;
         if (cand >= NumReq) begin
            cand = cand - NumReq;
         end
         if (!found && req_v_i[cand[IdxW-1:0]]) begin
            found                         = 1'b1;
            grant_oh_o[cand[IdxW-1:0]]    = 1'b1;
            grant_idx_o                   = cand[IdxW-1:0];
         end
      end
   end

endmodule

// File: rtl/mul_share_arb.sv
// Round-robin scheduler sharing one iterative multiplier among NumReq
// requesters, one operation in flight at a time.
//   clk_i, reset_i            : clock, synchronous active-high reset
//   req_v_i / req_ready_o     : per-requester request handshake
//   req_opA_i / req_opB_i     : per-requester operands
//   resp_v_o / resp_data_o    : one-hot result valid and shared result bus
//   resp_yumi_i               : per-requester result consume
//   mul_v_o / mul_ready_i     : operand handshake to the multiplier
//   mul_opA_o / mul_opB_o     : latched operands
//   mul_v_i / mul_result_i    : multiplier result
//   mul_yumi_o                : result consumed (combinational on mul_v_i in WAIT)
module mul_share_arb
   import mul_share_pkg::*;
#(
   parameter int unsigned NumReq = 2,
   parameter int unsigned Width  = 32
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic [NumReq-1:0]             req_v_i,
   output logic [NumReq-1:0]             req_ready_o,
   input  logic [NumReq-1:0][Width-1:0]  req_opA_i,
   input  logic [NumReq-1:0][Width-1:0]  req_opB_i,
   output logic [NumReq-1:0]             resp_v_o,
   output logic [Width-1:0]              resp_data_o,
   input  logic [NumReq-1:0]             resp_yumi_i,
   output logic                          mul_v_o,
   input  logic                          mul_ready_i,
   output logic [Width-1:0]              mul_opA_o,
   output logic [Width-1:0]              mul_opB_o,
   input  logic                          mul_v_i,
   input  logic [Width-1:0]              mul_result_i,
   output logic                          mul_yumi_o
);

   localparam int unsigned IdxW = idx_width(NumReq);

   state_e            state_q, state_d;
   logic [IdxW-1:0]   ptr_q, grant_q;
   logic [Width-1:0]  opa_q, opb_q, result_q;
   logic [NumReq-1:0] pick_oh;
   logic [IdxW-1:0]   pick_idx;
   logic              accept, mul_done, resp_done;

   mul_share_rr_pick #(
      .NumReq (NumReq),
      .IdxW   (IdxW)
   ) u_pick (
      .req_v_i     (req_v_i),
      .ptr_i       (ptr_q),
      .grant_oh_o  (pick_oh),
      .grant_idx_o (pick_idx)
   );

   assign accept    = (state_q == StIdle) && (|(req_v_i & pick_oh));
   assign mul_done  = (state_q == StWait) && mul_v_i;
   // Only the granted requester's consume bit counts.
   assign resp_done = (state_q == StResp) && resp_yumi_i[grant_q];

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept)      state_d = StIssue;
         StIssue: if (mul_ready_i) state_d = StWait;
         StWait:  if (mul_v_i)     state_d = StResp;
         StResp:  if (resp_done)   state_d = StIdle;
         default:                  state_d = StIdle;
      endcase
   end

   always_comb begin
      req_ready_o = '0;
      mul_v_o     = 1'b0;
      mul_yumi_o  = 1'b0;
      resp_v_o    = '0;
      unique case (state_q)
         StIdle:  req_ready_o       = pick_oh;
         StIssue: mul_v_o           = 1'b1;
         StWait:  mul_yumi_o        = mul_v_i;
         StResp:  resp_v_o[grant_q] = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         ptr_q    <= '0;
         grant_q  <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         result_q <= '0;
      end else begin
         if (accept) begin
            opa_q   <= req_opA_i[pick_idx];
            opb_q   <= req_opB_i[pick_idx];
            grant_q <= pick_idx;
         end
         if (mul_done) begin
            result_q <= mul_result_i;
         end
         if (resp_done) begin
            ptr_q <= (grant_q == IdxW'(NumReq - 1)) ? '0 : grant_q + IdxW'(1);
         end
      end
   end

   assign mul_opA_o   = opa_q;
   assign mul_opB_o   = opb_q;
   assign resp_data_o = result_q;

endmodule

// File: tb/tb_mul_share_arb.sv
module tb_mul_share_arb;

   localparam int unsigned N = 3;
   localparam int unsigned W = 32;

   logic                 clk = 1'b0;
   logic                 reset_i;
   logic [N-1:0]         req_v_i, req_ready_o, resp_v_o, resp_yumi_i;
   logic [N-1:0][W-1:0]  req_opA_i, req_opB_i;
   logic [W-1:0]         resp_data_o, mul_opA_o, mul_opB_o, mul_result_i;
   logic                 mul_v_o, mul_ready_i, mul_v_i, mul_yumi_o;

   int checks = 0;
   int errors = 0;
   int ptr_m  = 0;
   int g;

   mul_share_arb #(
      .NumReq (N),
      .Width  (W)
   ) dut (
      .clk_i        (clk),
      .reset_i      (reset_i),
      .req_v_i      (req_v_i),
      .req_ready_o  (req_ready_o),
      .req_opA_i    (req_opA_i),
      .req_opB_i    (req_opB_i),
      .resp_v_o     (resp_v_o),
      .resp_data_o  (resp_data_o),
      .resp_yumi_i  (resp_yumi_i),
      .mul_v_o      (mul_v_o),
      .mul_ready_i  (mul_ready_i),
      .mul_opA_o    (mul_opA_o),
      .mul_opB_o    (mul_opB_o),
      .mul_v_i      (mul_v_i),
      .mul_result_i (mul_result_i),
      .mul_yumi_o   (mul_yumi_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Round-robin rule: first active requester at or after ptr, wrapping.
   function automatic int model_pick(input logic [N-1:0] reqs, input int ptr);
      int j;
      for (int k = 0; k < N; k++) begin
         j = (ptr + k) % N;
         if (reqs[j]) return j;
      end
      return -1;
   endfunction

   // One full transaction driven by the bench acting as requesters and multiplier.
   task automatic do_op(input logic [N-1:0] reqs, input int lat, input int rdy_dly,
                        input int yumi_dly, output int gnt);
      int           eg;
      logic [N-1:0] oh;
      logic [W-1:0] prod;
      logic [63:0]  full;
      req_v_i = reqs;
      #1;
      eg   = model_pick(reqs, ptr_m);
      oh   = N'(1) << eg;
      full = 64'(req_opA_i[eg]) * 64'(req_opB_i[eg]);
      prod = full[W-1:0];
      chk("idle_ready", req_ready_o, oh);
      chk("idle_mul_v", mul_v_o, 0);
      chk("idle_resp_v", resp_v_o, 0);
      mul_v_i      = 1'b1;
      mul_result_i = $urandom;
      #1;
      chk("idle_spur_yumi", mul_yumi_o, 0);
      tick();
      mul_v_i = 1'b0;
      for (int c = 0; c < rdy_dly; c++) begin
         mul_ready_i = 1'b0;
         mul_v_i     = 1'($urandom_range(0, 1));
         #1;
         chk("issue_mul_v", mul_v_o, 1);
         chk("issue_opA", mul_opA_o, req_opA_i[eg]);
         chk("issue_opB", mul_opB_o, req_opB_i[eg]);
         chk("issue_ready", req_ready_o, 0);
         chk("issue_yumi", mul_yumi_o, 0);
         tick();
      end
      mul_v_i     = 1'b0;
      mul_ready_i = 1'b1;
      #1;
      chk("issue_mul_v", mul_v_o, 1);
      chk("issue_opA", mul_opA_o, req_opA_i[eg]);
      chk("issue_opB", mul_opB_o, req_opB_i[eg]);
      tick();
      mul_ready_i = 1'b0;
      for (int c = 0; c < lat; c++) begin
         #1;
         chk("wait_mul_v", mul_v_o, 0);
         chk("wait_yumi", mul_yumi_o, 0);
         chk("wait_resp_v", resp_v_o, 0);
         chk("wait_ready", req_ready_o, 0);
         tick();
      end
      mul_v_i      = 1'b1;
      mul_result_i = prod;
      #1;
      chk("wait_yumi_pulse", mul_yumi_o, 1);
      tick();
      mul_v_i      = 1'b0;
      mul_result_i = $urandom;
      for (int c = 0; c < yumi_dly; c++) begin
         resp_yumi_i = N'($urandom) & ~oh;
         mul_v_i     = 1'($urandom_range(0, 1));
         #1;
         chk("resp_v", resp_v_o, oh);
         chk("resp_data", resp_data_o, prod);
         chk("resp_ready", req_ready_o, 0);
         chk("resp_yumi", mul_yumi_o, 0);
         chk("resp_mul_v", mul_v_o, 0);
         tick();
      end
      mul_v_i     = 1'b0;
      resp_yumi_i = oh;
      #1;
      chk("resp_v", resp_v_o, oh);
      chk("resp_data", resp_data_o, prod);
      tick();
      resp_yumi_i = '0;
      ptr_m = (eg + 1) % N;
      gnt   = eg;
   endtask

   initial begin
      reset_i      = 1'b1;
      req_v_i      = '0;
      req_opA_i    = '0;
      req_opB_i    = '0;
      resp_yumi_i  = '0;
      mul_ready_i  = 1'b0;
      mul_v_i      = 1'b0;
      mul_result_i = '0;
      tick();
      tick();
      reset_i = 1'b0;
      #1;
      chk("rst_ready", req_ready_o, 0);
      chk("rst_resp_v", resp_v_o, 0);
      chk("rst_resp_data", resp_data_o, 0);
      chk("rst_mul_v", mul_v_o, 0);
      chk("rst_opA", mul_opA_o, 0);
      chk("rst_opB", mul_opB_o, 0);
      chk("rst_yumi", mul_yumi_o, 0);

      // Fairness between req0 and req1 from reset.
      req_opA_i[0] = 32'h0000_FFFF;
      req_opB_i[0] = 32'h0001_0001;
      req_opA_i[1] = 32'd5;
      req_opB_i[1] = 32'd5;
      for (int i = 0; i < 6; i++) begin
         do_op(3'b011, $urandom_range(0, 4), 0, 0, g);
         chk("fair_grant", g, i % 2);
      end

      // Single op with a 32-cycle multiplier.
      req_opA_i[0] = 32'd3;
      req_opB_i[0] = 32'd7;
      do_op(3'b001, 32, 0, 0, g);
      chk("single_grant", g, 0);

      // Backpressure on both sides, then spurious consume bits while serving req0.
      req_opA_i[1] = $urandom;
      req_opB_i[1] = $urandom;
      do_op(3'b010, 3, 10, 20, g);
      chk("bp_grant", g, 1);
      do_op(3'b001, 2, 2, 4, g);
      chk("spur_grant", g, 0);

      // Reset while waiting on the multiplier.
      req_v_i = 3'b110;
      tick();
      mul_ready_i = 1'b1;
      tick();
      mul_ready_i = 1'b0;
      tick();
      tick();
      reset_i = 1'b1;
      req_v_i = '0;
      tick();
      reset_i = 1'b0;
      #1;
      chk("rw_ready", req_ready_o, 0);
      chk("rw_resp_v", resp_v_o, 0);
      chk("rw_resp_data", resp_data_o, 0);
      chk("rw_mul_v", mul_v_o, 0);
      chk("rw_opA", mul_opA_o, 0);
      chk("rw_opB", mul_opB_o, 0);
      chk("rw_yumi", mul_yumi_o, 0);
      ptr_m = 0;
      for (int c = 0; c < 4; c++) begin
         mul_v_i     = 1'b1;
         resp_yumi_i = '1;
         #1;
         chk("rw_no_resp", resp_v_o, 0);
         chk("rw_no_yumi", mul_yumi_o, 0);
         tick();
      end
      mul_v_i     = 1'b0;
      resp_yumi_i = '0;
      for (int i = 0; i < N; i++) begin
         req_opA_i[i] = $urandom;
         req_opB_i[i] = $urandom;
      end
      for (int i = 0; i < 4; i++) begin
         do_op(3'b111, 1, 0, 0, g);
         chk("all_grant", g, i % 3);
      end

      // Pointer wrap: only req2, then only req0.
      do_op(3'b100, 1, 0, 0, g);
      chk("wrap_g2", g, 2);
      do_op(3'b001, 1, 0, 0, g);
      chk("wrap_g0", g, 0);

      // Randomized traffic.
      for (int i = 0; i < 20; i++) begin
         for (int r = 0; r < N; r++) begin
            req_opA_i[r] = $urandom;
            req_opB_i[r] = $urandom;
         end
         do_op(N'($urandom_range(1, 7)), $urandom_range(0, 6), $urandom_range(0, 3),
               $urandom_range(0, 3), g);
      end

      req_v_i = '0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
